booth_seq_mult: RTL
===================

# booth_seq_mult

Sequential radix-2 Booth multiplier, parametrised in operand width, with a per-operation signed/unsigned mode and a start/busy/done handshake. It replaces the combinational Booth array where area matters more than latency: one add/subtract-and-shift step per clock, fixed latency independent of operand values. It sits behind any datapath that can issue a multiply and wait for `done`.

## Interface

- `WIDTH`, default 8: operand width in bits; must be at least 2. The product is 2*WIDTH bits.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request pulse; sampled only in IDLE.
- `is_signed`  input  1  1: operands are two's complement; 0: operands are unsigned. Sampled with `start`.
- `input_A`  input  WIDTH  multiplicand; sampled with `start`.
- `input_B`  input  WIDTH  multiplier; sampled with `start`.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse when `C` becomes valid.
- `C`  output  2*WIDTH  product. Registered and held until the next `done`.

## Operation

- State machine IDLE -> BUSY -> DONE -> IDLE.
- **IDLE**
  - `start`=1 captures `input_A`, `input_B` and `is_signed` and moves to BUSY.
  - Each operand is extended to WIDTH+1 bits: sign-extended when `is_signed`=1, zero-extended otherwise.
  - Load: multiplicand M (WIDTH+1 bits); accumulator P_hi = 0 (WIDTH+2 bits); Q = extended B (WIDTH+1 bits); q_m1 = 0; step counter = WIDTH+1.
- **BUSY**: one Booth step per cycle, decided on the pair {Q[0], q_m1}:
  - 01: P_hi += M (M sign-extended to WIDTH+2 bits).
  - 10: P_hi -= M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {P_hi, Q, q_m1} by one bit.
  - Counter decrements. The step that brings the counter to 0 is the last step; it moves to DONE.
- **DONE**
  - `C` <= low 2*WIDTH bits of {P_hi, Q}.
  - `done`=1 for exactly this cycle, then return to IDLE.
- The WIDTH+2-bit accumulator prevents overflow on -M when M = -2^WIDTH. The result is exact for every operand pair in both modes.
- `start` in BUSY or DONE is ignored. The operation in flight is not disturbed, and the request is not queued.
- `input_A`, `input_B` and `is_signed` may change freely after the capture cycle.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `C`=0, all internal registers 0. Reset takes effect immediately, without waiting for a clock edge.
- Latency, from `start` sampled at clock edge k:
  - `busy`=1 after edge k.
  - The BUSY steps occupy edges k+1 through k+WIDTH+1.
  - `done`=1 and `C` valid after edge k+WIDTH+2; for WIDTH=8, 10 cycles.
  - `busy` falls after edge k+WIDTH+3.
- Throughput: a new `start` is accepted in the first IDLE cycle after DONE, i.e. one operation per WIDTH+3 cycles.
- `done` and the update of `C` are coincident. `C` is stable at all other times.
- Reset asserted mid-operation aborts it: the block is in IDLE with `C`=0 and no `done` pulse. The first `start` after reset release behaves normally.
- `start` held high continuously starts a new operation on every IDLE cycle; there is no edge detection.

## Test plan

- WIDTH=8, signed, A=124, B=73, single `start` -> `done` exactly 10 cycles after the start edge; `C`=9052 (0x235C); `busy` high for 11 cycles.
- Signed corner operands, each in its own operation -> results:
  - A=-128, B=-128 -> C=16384.
  - A=-1, B=1 -> C=0xFFFF.
  - A=-128, B=127 -> C=-16256.
  - A=0, B=-77 -> C=0.
- Unsigned mode:
  - A=255, B=255 -> C=65025 (0xFE01).
  - A=200, B=3 -> C=600.
  - The same bit patterns in signed mode give 1 and -168 respectively.
- Requests while busy: `start` pulsed with A=5, B=5 three cycles into a 124*73 operation -> ignored; `C`=9052, one `done` only.
  - A second `start` (A=5, B=5) in the first IDLE cycle after `done` -> C=25 after 10 more cycles.
- Reset mid-operation: assert `rst` asynchronously, between clock edges, in the fifth BUSY cycle -> `busy`, `done` and `C` are 0 immediately; no `done` pulse follows.
  - Next operation (A=-3, B=7) -> C=-21.
- Randomised sweep, WIDTH=8 and WIDTH=16: 1000 random operands and modes compared against a behavioural `*` model -> zero mismatches; latency is always WIDTH+2.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// signed or unsigned operands selected per operation, start/busy/done handshake.
module booth_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     input_A,
  input  logic [WIDTH-1:0]     input_B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   C
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;
  logic [WIDTH+1:0]   phi_q, phi_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               done_q, done_d;

  logic [WIDTH+1:0]   m_ext;
  logic [WIDTH+1:0]   sum;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    phi_d   = phi_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    done_d  = 1'b0;

    m_ext = {m_q[WIDTH], m_q};
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = phi_q + m_ext;
      2'b10:   sum = phi_q - m_ext;
      default: sum = phi_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {is_signed & input_A[WIDTH-1], input_A};
          q_d     = {is_signed & input_B[WIDTH-1], input_B};
          phi_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH + 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Arithmetic right shift of {P_hi, Q, q_m1} applied to the post-add accumulator.
        phi_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_d   = {sum[0], q_q[WIDTH:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        c_d     = {phi_q[WIDTH-2:0], q_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      phi_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      phi_q   <= phi_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  // The done cycle is already IDLE (so a new start is accepted) but still reports busy.
  assign busy = (state_q != IDLE) | done_q;
  assign done = done_q;
  assign C    = c_q;

endmodule
